// File: rtl/ipg_msg_rx.sv
// Passive XGMII RX tap that pulls inter-packet-gap control messages off the bus,
// reassembles them into a store-and-forward FIFO and streams them out with tlast framing.
//
// state | meaning
// GAP   | between packets, looking for message start words
// PKT   | inside an Ethernet frame, message words ignored until TERM
// MSG   | collecting continuation words of an accepted message
module ipg_msg_rx #(
   parameter int         DATA_WIDTH     = 64,
   parameter int         CTRL_WIDTH     = DATA_WIDTH / 8,
   parameter logic [7:0] MSG_START_CHAR = 8'h5C,
   parameter logic [7:0] MSG_CONT_CHAR  = 8'h3C,
   parameter int         MAX_WORDS      = 8,
   parameter int         FIFO_DEPTH     = 32
) (
   input  logic                  rx_clk,
   input  logic                  rx_rst,
   input  logic [DATA_WIDTH-1:0] xgmii_rxd,
   input  logic [CTRL_WIDTH-1:0] xgmii_rxc,
   output logic [47:0]           m_msg_tdata,
   output logic                  m_msg_tvalid,
   input  logic                  m_msg_tready,
   output logic                  m_msg_tlast,
   output logic [15:0]           rx_msg_count,
   output logic [15:0]           rx_msg_drop,
   output logic [15:0]           rx_msg_error
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int FW = AW + 2;
   typedef logic [AW:0]   ptr_t;
   typedef logic [FW-1:0] fw_t;
   localparam logic [7:0] MAX_L   = 8'(MAX_WORDS - 1);
   localparam fw_t        DEPTH_W = fw_t'(FIFO_DEPTH);

   typedef enum logic [1:0] {GAP, PKT, MSG} state_t;

   state_t      state_q, state_d;
   ptr_t        wr_tent_q, wr_tent_d;
   ptr_t        wr_comm_q, wr_comm_d;
   ptr_t        rd_q, rd_d;
   logic [7:0]  len_q, len_d;
   logic [7:0]  idx_q, idx_d;
   logic [47:0] tdata_q;
   logic        tlast_q;
   logic        tvalid_q, tvalid_d;
   logic [15:0] cnt_q, cnt_d;
   logic [15:0] drop_q, drop_d;
   logic [15:0] err_q, err_d;
   logic [48:0] mem [FIFO_DEPTH];

   logic        is_start, is_term, is_msgs, is_msgc;
   logic [7:0]  hdr;
   logic [47:0] chunk;
   ptr_t        base, occ;
   fw_t         free_w;
   logic        take_new, wr_en, wr_last, commit, drop_inc, load;
   logic [1:0]  err_inc;
   logic [16:0] err_sum;

   assign hdr      = xgmii_rxd[15:8];
   assign chunk    = xgmii_rxd[63:16];
   assign is_start = (xgmii_rxc[0] && xgmii_rxd[7:0] == 8'hFB) ||
                     (xgmii_rxc == 8'h1F && xgmii_rxd[39:32] == 8'hFB);
   assign is_msgs  = (xgmii_rxc == 8'h01) && (xgmii_rxd[7:0] == MSG_START_CHAR);
   assign is_msgc  = (xgmii_rxc == 8'h01) && (xgmii_rxd[7:0] == MSG_CONT_CHAR);

   always_comb begin
      is_term = 1'b0;
      for (int i = 0; i < CTRL_WIDTH; i++) begin
         if (xgmii_rxc[i] && xgmii_rxd[8*i +: 8] == 8'hFD) is_term = 1'b1;
      end
   end

   // The word parked in the output register still occupies a slot, so the
   // store never holds more than FIFO_DEPTH words in total.
   assign occ    = base - rd_q;
   assign free_w = DEPTH_W - fw_t'(occ) - fw_t'(tvalid_q);

   always_comb begin
      state_d   = state_q;
      wr_tent_d = wr_tent_q;
      wr_comm_d = wr_comm_q;
      len_d     = len_q;
      idx_d     = idx_q;
      base      = wr_tent_q;
      take_new  = 1'b0;
      wr_en     = 1'b0;
      wr_last   = 1'b0;
      commit    = 1'b0;
      drop_inc  = 1'b0;
      err_inc   = 2'd0;

      case (state_q)
         GAP: begin
            if (is_start)     state_d = PKT;
            else if (is_msgs) take_new = 1'b1;
         end
         PKT: begin
            if (is_term && !is_start) state_d = GAP;
         end
         MSG: begin
            if (is_msgc && hdr == idx_q) begin
               wr_en   = 1'b1;
               wr_last = (idx_q == len_q);
               if (idx_q == len_q) begin
                  commit  = 1'b1;
                  state_d = GAP;
               end else begin
                  idx_d = idx_q + 8'd1;
               end
            end else begin
               err_inc   = 2'd1;
               base      = wr_comm_q;
               wr_tent_d = wr_comm_q;
               state_d   = GAP;
               if (is_start)     state_d = PKT;
               else if (is_msgs) take_new = 1'b1;
            end
         end
         default: state_d = GAP;
      endcase

      if (take_new) begin
         state_d = GAP;
         if (hdr > MAX_L) begin
            err_inc = err_inc + 2'd1;
         end else if (free_w < fw_t'(hdr) + fw_t'(1)) begin
            drop_inc = 1'b1;
         end else begin
            wr_en   = 1'b1;
            wr_last = (hdr == 8'd0);
            if (hdr == 8'd0) begin
               commit = 1'b1;
            end else begin
               state_d = MSG;
               len_d   = hdr;
               idx_d   = 8'd1;
            end
         end
      end

      if (wr_en)  wr_tent_d = base + ptr_t'(1);
      if (commit) wr_comm_d = base + ptr_t'(1);
   end

   // Output register reloads whenever it is empty or being drained.
   always_comb begin
      load     = (!tvalid_q || m_msg_tready) && (rd_q != wr_comm_q);
      rd_d     = rd_q + ptr_t'(load);
      tvalid_d = tvalid_q;
      if (load)              tvalid_d = 1'b1;
      else if (m_msg_tready) tvalid_d = 1'b0;
   end

   always_comb begin
      cnt_d   = (commit && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
      drop_d  = (drop_inc && drop_q != 16'hFFFF) ? drop_q + 16'd1 : drop_q;
      err_sum = {1'b0, err_q} + {15'd0, err_inc};
      err_d   = err_sum[16] ? 16'hFFFF : err_sum[15:0];
   end

   always_ff @(posedge rx_clk) begin
      if (rx_rst) begin
         state_q   <= GAP;
         wr_tent_q <= '0;
         wr_comm_q <= '0;
         rd_q      <= '0;
         len_q     <= '0;
         idx_q     <= '0;
         tdata_q   <= '0;
         tlast_q   <= 1'b0;
         tvalid_q  <= 1'b0;
         cnt_q     <= '0;
         drop_q    <= '0;
         err_q     <= '0;
      end else begin
         state_q   <= state_d;
         wr_tent_q <= wr_tent_d;
         wr_comm_q <= wr_comm_d;
         rd_q      <= rd_d;
         len_q     <= len_d;
         idx_q     <= idx_d;
         tvalid_q  <= tvalid_d;
         cnt_q     <= cnt_d;
         drop_q    <= drop_d;
         err_q     <= err_d;
         if (load) {tlast_q, tdata_q} <= mem[rd_q[AW-1:0]];
      end
   end

   always_ff @(posedge rx_clk) begin
      if (wr_en) mem[base[AW-1:0]] <= {wr_last, chunk};
   end

   assign m_msg_tdata  = tdata_q;
   assign m_msg_tlast  = tlast_q;
   assign m_msg_tvalid = tvalid_q;
   assign rx_msg_count = cnt_q;
   assign rx_msg_drop  = drop_q;
   assign rx_msg_error = err_q;

endmodule

// File: tb/tb_ipg_msg_rx.sv
// Directed bench for ipg_msg_rx: hand-built XGMII word sequences with expected
// beats and counter values; output beats are captured by a monitor and scoreboarded.
module tb_ipg_msg_rx;

   logic        clk = 1'b0;
   logic        rst;
   logic [63:0] rxd;
   logic [7:0]  rxc;
   logic [47:0] tdata;
   logic        tvalid, tready, tlast;
   logic [15:0] cnt, drop, err;

   int checks = 0;
   int errors = 0;
   int stall_err = 0;
   logic [48:0] got_q[$];
   logic [48:0] exp_q[$];

   localparam logic [63:0] IDLE_D   = {8{8'h07}};
   localparam logic [63:0] START_D  = 64'hD5555555555555FB;
   localparam logic [63:0] TERM_D   = 64'h07070707070707FD;
   localparam logic [63:0] L4_D     = 64'h555555FB070707FD;
   localparam logic [63:0] DATA_D   = 64'h0011223344556677;

   always #5 clk = ~clk;

   ipg_msg_rx dut (
      .rx_clk       (clk),
      .rx_rst       (rst),
      .xgmii_rxd    (rxd),
      .xgmii_rxc    (rxc),
      .m_msg_tdata  (tdata),
      .m_msg_tvalid (tvalid),
      .m_msg_tready (tready),
      .m_msg_tlast  (tlast),
      .rx_msg_count (cnt),
      .rx_msg_drop  (drop),
      .rx_msg_error (err)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   // Captures transferred beats and flags any change of a stalled beat.
   logic        prev_stall = 1'b0;
   logic [48:0] prev_beat  = '0;
   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_stall = 1'b0;
         end else begin
            if (prev_stall && (!tvalid || {tlast, tdata} != prev_beat)) stall_err++;
            if (tvalid && tready) got_q.push_back({tlast, tdata});
            prev_stall = tvalid && !tready;
            prev_beat  = {tlast, tdata};
         end
      end
   end

   task automatic step(input logic [7:0] c, input logic [63:0] d);
      rxc = c;
      rxd = d;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(8'hFF, IDLE_D);
   endtask

   task automatic send_s(input logic [7:0] h, input logic [47:0] p);
      step(8'h01, {p, h, 8'h5C});
   endtask

   task automatic send_c(input logic [7:0] h, input logic [47:0] p);
      step(8'h01, {p, h, 8'h3C});
   endtask

   task automatic expect_beat(input logic last, input logic [47:0] p);
      exp_q.push_back({last, p});
   endtask

   // Waits (bounded) for every expected beat, lingers to catch extras, then compares.
   task automatic drain(input string tag);
      int n = 0;
      int k;
      while (got_q.size() < exp_q.size() && n < 300) begin
         idle(1);
         n++;
      end
      idle(4);
      chk({tag, "_beats"}, 64'(got_q.size()), 64'(exp_q.size()));
      k = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < k; i++) chk($sformatf("%s_beat%0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
      got_q.delete();
      exp_q.delete();
   endtask

   initial begin
      rst    = 1'b1;
      rxc    = 8'hFF;
      rxd    = IDLE_D;
      tready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      chk("rst_tvalid", 64'(tvalid), 64'd0);
      chk("rst_count", 64'(cnt), 64'd0);
      chk("rst_drop", 64'(drop), 64'd0);
      chk("rst_error", 64'(err), 64'd0);

      // single-word message and its output latency
      idle(2);
      send_s(8'd0, 48'h0123456789AB);
      chk("t1_valid_t1", 64'(tvalid), 64'd0);
      idle(1);
      chk("t1_valid_t2", 64'(tvalid), 64'd1);
      chk("t1_data", 64'(tdata), 64'h0123456789AB);
      chk("t1_last", 64'(tlast), 64'd1);
      expect_beat(1'b1, 48'h0123456789AB);
      drain("t1");
      chk("t1_count", 64'(cnt), 64'd1);

      // three-word message under backpressure
      tready = 1'b0;
      send_s(8'd2, 48'hAAAA00000001);
      send_c(8'd1, 48'hBBBB00000002);
      send_c(8'd2, 48'hCCCC00000003);
      idle(5);
      chk("t2_stall_valid", 64'(tvalid), 64'd1);
      chk("t2_stall_data", 64'(tdata), 64'hAAAA00000001);
      chk("t2_stall_last", 64'(tlast), 64'd0);
      tready = 1'b1;
      expect_beat(1'b0, 48'hAAAA00000001);
      expect_beat(1'b0, 48'hBBBB00000002);
      expect_beat(1'b1, 48'hCCCC00000003);
      drain("t2");
      chk("t2_count", 64'(cnt), 64'd2);

      // bad continuation index, then a good message
      send_s(8'd2, 48'h111111111111);
      send_c(8'd2, 48'h222222222222);
      idle(3);
      chk("t3_error", 64'(err), 64'd1);
      chk("t3_count", 64'(cnt), 64'd2);
      send_s(8'd0, 48'hD00D00D00D00);
      expect_beat(1'b1, 48'hD00D00D00D00);
      drain("t3");
      chk("t3_count2", 64'(cnt), 64'd3);

      // interruption by a frame start; messages inside the frame are ignored
      send_s(8'd3, 48'h333333333333);
      send_c(8'd1, 48'h444444444444);
      step(8'h01, START_D);
      send_s(8'd0, 48'hBADBADBADBAD);
      step(8'h00, DATA_D);
      step(8'hFF, TERM_D);
      chk("t4_error", 64'(err), 64'd2);
      send_s(8'd0, 48'hEEEE0000EEEE);
      expect_beat(1'b1, 48'hEEEE0000EEEE);
      drain("t4");
      chk("t4_count", 64'(cnt), 64'd4);

      // lane-4 start right after a terminate keeps the tap inside a frame
      step(8'h01, START_D);
      step(8'h00, DATA_D);
      step(8'h1F, L4_D);
      send_s(8'd0, 48'hBADBADBAD000);
      step(8'h00, DATA_D);
      step(8'hFF, TERM_D);
      send_s(8'd0, 48'hF00DF00DF00D);
      expect_beat(1'b1, 48'hF00DF00DF00D);
      drain("t4b");
      chk("t4b_count", 64'(cnt), 64'd5);
      chk("t4b_error", 64'(err), 64'd2);

      // fill the store exactly, then one more message must be dropped
      tready = 1'b0;
      for (int m = 0; m < 4; m++) begin
         send_s(8'd0 + 8'd7, {32'hCAFE0000, 8'(m), 8'd0});
         expect_beat(1'b0, {32'hCAFE0000, 8'(m), 8'd0});
         for (int w = 1; w < 8; w++) begin
            send_c(8'(w), {32'hCAFE0000, 8'(m), 8'(w)});
            expect_beat(w == 7, {32'hCAFE0000, 8'(m), 8'(w)});
         end
      end
      send_s(8'd0, 48'h999999999999);
      idle(3);
      chk("t5_drop", 64'(drop), 64'd1);
      chk("t5_count", 64'(cnt), 64'd9);
      chk("t5_error", 64'(err), 64'd2);
      tready = 1'b1;
      drain("t5");

      // over-length header, then reset in the middle of a message
      send_s(8'd8, 48'h888888888888);
      idle(2);
      chk("t6_error", 64'(err), 64'd3);
      drain("t6");
      send_s(8'd3, 48'h777777777777);
      send_c(8'd1, 48'h666666666666);
      rst = 1'b1;
      idle(2);
      rst = 1'b0;
      send_c(8'd2, 48'h555555555555);
      send_c(8'd3, 48'h444444444444);
      idle(3);
      chk("t6_rst_count", 64'(cnt), 64'd0);
      chk("t6_rst_drop", 64'(drop), 64'd0);
      chk("t6_rst_error", 64'(err), 64'd0);
      chk("t6_rst_valid", 64'(tvalid), 64'd0);
      drain("t6_rst");
      send_s(8'd0, 48'h123412341234);
      expect_beat(1'b1, 48'h123412341234);
      drain("t6_post");
      chk("t6_post_count", 64'(cnt), 64'd1);

      chk("stall_stability", 64'(stall_err), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
